// File: rtl/cmp_sort_pkg.sv
// Shared constants for the compare-and-sort sequencer: FSM state encoding and default sizing.
package cmp_sort_pkg;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SORT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/cmp_ge.sv
// Unsigned magnitude comparator, a >= b. The only magnitude-compare resource in the sorter.
module cmp_ge #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ge
);

  assign ge = (a >= b);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Load / bubble-sort / drain sequencer around one shared >= comparator.
// Optional build macro SORT_EARLY_EXIT_EN: finish sorting after the first pass with no swaps.
//
// state   | meaning
// S_LOAD  | accepting DEPTH input words into the buffer
// S_SORT  | one compare-and-swap of mem[i], mem[i+1] per cycle
// S_DRAIN | streaming sorted words out, ascending
module cmp_sort_ctrl
  import cmp_sort_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_CMP = IW'(DEPTH - 2);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    cmp_idx;
  logic [IW-1:0]    cmp_hi;
  logic [IW-1:0]    rd_hi;
  logic [IW-1:0]    pass_idx;
  logic [WIDTH-1:0] mem      [DEPTH];
  logic [WIDTH-1:0] mem_next [DEPTH];
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             a_ge_b;
  logic             swap;
  logic             in_fire;
  logic             out_fire;
  logic             pass_end;
  logic             sort_done;

  assign cmp_hi = cmp_idx + IW'(1);
  assign rd_hi  = rd_idx + IW'(1);
  assign cmp_a  = mem[cmp_hi];
  assign cmp_b  = mem[cmp_idx];

  cmp_ge #(.WIDTH(WIDTH)) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .ge (a_ge_b)
  );

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign swap     = (state == S_SORT) && !a_ge_b;
  assign pass_end = (cmp_idx == LAST_CMP);

`ifdef SORT_EARLY_EXIT_EN
  logic swap_seen;

  // A pass that finishes with no swap anywhere proves the buffer is already ordered.
  assign sort_done = pass_end && ((pass_idx == LAST_CMP) || !(swap_seen || swap));

  always_ff @(posedge clk) begin
    if (!rst_n)
      swap_seen <= 1'b0;
    else if (state == S_SORT)
      swap_seen <= pass_end ? 1'b0 : (swap_seen || swap);
  end
`else
  assign sort_done = pass_end && (pass_idx == LAST_CMP);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= S_LOAD;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:  if (in_fire && (wr_idx == LAST_IDX)) state_next = S_SORT;
      S_SORT:  if (sort_done) state_next = S_DRAIN;
      S_DRAIN: if (out_fire && (rd_idx == LAST_IDX)) state_next = S_LOAD;
      default: state_next = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_LOAD);
    out_valid = (state == S_DRAIN);
    busy      = (state == S_SORT);
  end

  // Strict swap only when mem[i+1] < mem[i], so equal words keep their order.
  always_comb begin
    mem_next = mem;
    if (in_fire)
      mem_next[wr_idx] = in_data;
    if (swap) begin
      mem_next[cmp_idx] = cmp_a;
      mem_next[cmp_hi]  = cmp_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n)
      mem <= mem_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      cmp_idx  <= '0;
      pass_idx <= '0;
      out_data <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_fire)
            wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IW'(1);
        end
        S_SORT: begin
          if (pass_end) begin
            cmp_idx  <= '0;
            pass_idx <= sort_done ? '0 : pass_idx + IW'(1);
          end else begin
            cmp_idx <= cmp_hi;
          end
          // The first word out must reflect the final swap, hence mem_next.
          if (sort_done)
            out_data <= mem_next[0];
        end
        S_DRAIN: begin
          if (out_fire) begin
            rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_hi;
            if (rd_idx != LAST_IDX)
              out_data <= mem[rd_hi];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
